// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and small helpers for the 4-bit HD44780-style LCD controller.
package lcd_pkg;

  // Bit positions inside the {E, RS, RW} control bus
  localparam int CTRL_E  = 2;
  localparam int CTRL_RS = 1;
  localparam int CTRL_RW = 0;

  // Instruction codes used by the controller
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] HOME      = 8'h02;
  localparam logic [7:0] HOME_ALT  = 8'h03;
  localparam logic [7:0] FUNC_4B2L = 8'h28;
  localparam logic [7:0] ENTRY     = 8'h06;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] SET_DDRAM = 8'h80;

  // Timing constants in nanoseconds
  localparam longint unsigned T_PWR_NS   = 64'd15_000_000;
  localparam longint unsigned T_INIT0_NS = 64'd4_100_000;
  localparam longint unsigned T_INIT1_NS = 64'd100_000;
  localparam longint unsigned T_CMD_NS   = 64'd40_000;
  localparam longint unsigned T_CLR_NS   = 64'd1_640_000;
  localparam longint unsigned T_GAP_NS   = 64'd1_000;
  localparam longint unsigned T_SETUP_NS = 64'd40;
  localparam longint unsigned T_EHIGH_NS = 64'd230;
  localparam longint unsigned T_HOLD_NS  = 64'd10;

  // ceil(t * clk_hz) cycles, at least 1; waits of 1 us or more are shortened by scale
  function automatic int unsigned wait_cycles(input longint unsigned t_ns,
                                              input longint unsigned clk_hz,
                                              input longint unsigned scale);
    longint unsigned c;
    c = (t_ns * clk_hz + 64'd999_999_999) / 64'd1_000_000_000;
    if (t_ns >= 64'd1000) c = c / ((scale == 64'd0) ? 64'd1 : scale);
    if (c < 64'd1) c = 64'd1;
    return 32'(c);
  endfunction

  // DDRAM start address of each display row
  function automatic logic [6:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    return 7'h00;
      2'd1:    return 7'h40;
      2'd2:    return 7'h14;
      default: return 7'h54;
    endcase
  endfunction

  // Nibbles of the power-on wake-up sequence
  function automatic logic [3:0] init_nibble(input logic [1:0] i);
    return (i == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  // Configuration bytes sent once the bus is in 4-bit mode
  function automatic logic [7:0] cfg_byte(input logic [1:0] i);
    case (i)
      2'd0:    return FUNC_4B2L;
      2'd1:    return ENTRY;
      2'd2:    return DISP_ON;
      default: return CLEAR;
    endcase
  endfunction

  // Instructions that need the long settle time and home the cursor
  function automatic logic is_slow_cmd(input logic [7:0] b);
    return (b == CLEAR) || (b == HOME) || (b == HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: drives one nibble onto the bus with setup, E-high and hold timing.
module lcd_nibble_tx #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned E_CYC     = 12,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] nib,
  input  logic       rs,
  output logic       done,
  output logic [3:0] data,
  output logic       rs_out,
  output logic       e
);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_SETUP = 2'd1;
  localparam logic [1:0] TX_HIGH  = 2'd2;
  localparam logic [1:0] TX_HOLD  = 2'd3;

  localparam int unsigned CMAX = (E_CYC > SETUP_CYC) ?
                                 ((E_CYC > HOLD_CYC) ? E_CYC : HOLD_CYC) :
                                 ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC);
  localparam int CW = $clog2(CMAX + 1);

  logic [1:0]    phase;
  logic [CW-1:0] cnt;

  // Data and RS are only loaded while E is low; E pulses for exactly E_CYC cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= TX_IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      data   <= 4'h0;
      rs_out <= 1'b0;
      e      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (phase)
        TX_IDLE: if (start) begin
          data   <= nib;
          rs_out <= rs;
          cnt    <= CW'(SETUP_CYC - 1);
          phase  <= TX_SETUP;
        end
        TX_SETUP: if (cnt == '0) begin
          e     <= 1'b1;
          cnt   <= CW'(E_CYC - 1);
          phase <= TX_HIGH;
        end else cnt <= cnt - 1'b1;
        TX_HIGH: if (cnt == '0) begin
          e     <= 1'b0;
          cnt   <= CW'(HOLD_CYC - 1);
          phase <= TX_HOLD;
        end else cnt <= cnt - 1'b1;
        default: if (cnt == '0) begin
          done  <= 1'b1;
          phase <= TX_IDLE;
        end else cnt <= cnt - 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/lcd_nibble_ctrl.sv
// lcd_nibble_ctrl: power-on init, config and cursor-tracking character writes over a 4-bit LCD bus.
module lcd_nibble_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned COLS       = 16,
  parameter int unsigned ROWS       = 2,
  parameter int unsigned TIME_SCALE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       ch_valid,
  input  logic [7:0] ch_data,
  output logic       ch_ready,
  output logic       init_done,
  output logic [3:0] dataout,
  output logic [2:0] control
);

  localparam logic [2:0] PWR_WAIT  = 3'd0;
  localparam logic [2:0] INIT_NIB  = 3'd1;
  localparam logic [2:0] CFG       = 3'd2;
  localparam logic [2:0] IDLE      = 3'd3;
  localparam logic [2:0] ADDR      = 3'd4;
  localparam logic [2:0] SEND      = 3'd5;
  localparam logic [2:0] POST_WAIT = 3'd6;

  localparam logic [1:0] S_HI   = 2'd0;
  localparam logic [1:0] S_HI_W = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_LO_W = 2'd3;

  localparam int unsigned C_PWR   = wait_cycles(T_PWR_NS,   CLK_HZ, TIME_SCALE);
  localparam int unsigned C_INIT0 = wait_cycles(T_INIT0_NS, CLK_HZ, TIME_SCALE);
  localparam int unsigned C_INIT1 = wait_cycles(T_INIT1_NS, CLK_HZ, TIME_SCALE);
  localparam int unsigned C_CMD   = wait_cycles(T_CMD_NS,   CLK_HZ, TIME_SCALE);
  localparam int unsigned C_CLR   = wait_cycles(T_CLR_NS,   CLK_HZ, TIME_SCALE);
  localparam int unsigned C_GAP   = wait_cycles(T_GAP_NS,   CLK_HZ, TIME_SCALE);
  localparam int unsigned C_SETUP = wait_cycles(T_SETUP_NS, CLK_HZ, TIME_SCALE);
  localparam int unsigned C_EHIGH = wait_cycles(T_EHIGH_NS, CLK_HZ, TIME_SCALE);
  localparam int unsigned C_HOLD  = wait_cycles(T_HOLD_NS,  CLK_HZ, TIME_SCALE);

  // The power-on idle is always the longest scaled wait, so it sizes the counter
  localparam int WAIT_W = (C_PWR > 1) ? $clog2(C_PWR) : 1;
  typedef logic [WAIT_W-1:0] wait_t;
  localparam wait_t W_PWR   = wait_t'(C_PWR - 1);
  localparam wait_t W_INIT0 = wait_t'(C_INIT0 - 1);
  localparam wait_t W_INIT1 = wait_t'(C_INIT1 - 1);
  localparam wait_t W_CMD   = wait_t'(C_CMD - 1);
  localparam wait_t W_CLR   = wait_t'(C_CLR - 1);
  localparam wait_t W_GAP   = wait_t'(C_GAP - 1);

  localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);
  localparam logic [5:0] COLS_L   = 6'(COLS);

  logic [2:0] state, ret;
  logic [1:0] sub, idx, row, next_row, hit_row;
  logic [5:0] col, hit_col;
  wait_t      cnt, lim, init_lim, post_lim;
  logic [7:0] cur_byte, pend_ch, tx_byte;
  logic       rs_q, init_done_q, sending, addr_hit;
  logic       tx_start, tx_done, tx_e, tx_rs, tx_rs_in;
  logic [3:0] tx_data, tx_nib;

  // Pick the nibble to send and when to kick the transmitter
  always_comb begin
    sending  = (state == CFG) || (state == ADDR) || (state == SEND);
    tx_byte  = (state == CFG) ? cfg_byte(idx) : cur_byte;
    tx_rs_in = (state == SEND) && rs_q;
    tx_start = 1'b0;
    tx_nib   = tx_byte[7:4];
    if (state == INIT_NIB) begin
      tx_nib   = init_nibble(idx);
      tx_start = (sub == S_HI);
    end else if (sending) begin
      if (sub == S_HI) begin
        tx_start = 1'b1;
      end else if ((sub == S_GAP) && (cnt == lim)) begin
        tx_start = 1'b1;
        tx_nib   = tx_byte[3:0];
      end
    end
    case (idx)
      2'd0:    init_lim = W_INIT0;
      2'd1:    init_lim = W_INIT1;
      default: init_lim = W_CMD;
    endcase
    post_lim = (!tx_rs_in && is_slow_cmd(tx_byte)) ? W_CLR : W_CMD;
  end

  // Decode a Set-DDRAM address back into a visible (row, col); lowest row wins on overlap
  always_comb begin
    next_row = (row == LAST_ROW) ? 2'd0 : row + 2'd1;
    addr_hit = 1'b0;
    hit_row  = 2'd0;
    hit_col  = 6'd0;
    for (int r = 3; r >= 0; r--) begin
      if (r < int'(ROWS)) begin
        if (({1'b0, cmd_data[6:0]} >= {1'b0, row_base(2'(r))}) &&
            ({1'b0, cmd_data[6:0]} < ({1'b0, row_base(2'(r))} + 8'(COLS)))) begin
          addr_hit = 1'b1;
          hit_row  = 2'(r);
          hit_col  = 6'(cmd_data[6:0] - row_base(2'(r)));
        end
      end
    end
  end

  // Main sequencer: power-on wait, wake-up nibbles, config bytes, then serve requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PWR_WAIT;
      ret         <= PWR_WAIT;
      sub         <= S_HI;
      idx         <= 2'd0;
      row         <= 2'd0;
      col         <= 6'd0;
      cnt         <= '0;
      lim         <= '0;
      cur_byte    <= 8'h00;
      pend_ch     <= 8'h00;
      rs_q        <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state)
        PWR_WAIT: if (cnt == W_PWR) begin
          cnt   <= '0;
          idx   <= 2'd0;
          sub   <= S_HI;
          state <= INIT_NIB;
        end else cnt <= cnt + 1'b1;
        INIT_NIB: if (sub == S_HI) begin
          sub <= S_HI_W;
        end else if (tx_done) begin
          lim   <= init_lim;
          cnt   <= '0;
          ret   <= (idx == 2'd3) ? CFG : INIT_NIB;
          idx   <= idx + 2'd1;
          state <= POST_WAIT;
        end
        CFG, ADDR, SEND: case (sub)
          S_HI:   sub <= S_HI_W;
          S_HI_W: if (tx_done) begin
            lim <= W_GAP;
            cnt <= '0;
            sub <= S_GAP;
          end
          S_GAP: if (cnt == lim) begin
            cnt <= '0;
            sub <= S_LO_W;
          end else cnt <= cnt + 1'b1;
          default: if (tx_done) begin
            lim   <= post_lim;
            cnt   <= '0;
            state <= POST_WAIT;
            if (state == CFG) begin
              ret <= (idx == 2'd3) ? IDLE : CFG;
              idx <= idx + 2'd1;
            end else if (state == ADDR) begin
              ret <= SEND;
            end else begin
              ret <= IDLE;
            end
          end
        endcase
        POST_WAIT: if (cnt == lim) begin
          cnt   <= '0;
          sub   <= S_HI;
          state <= ret;
          if (ret == IDLE) init_done_q <= 1'b1;
          if (ret == SEND) begin
            cur_byte <= pend_ch;
            rs_q     <= 1'b1;
            col      <= col + 6'd1;
          end
        end else cnt <= cnt + 1'b1;
        IDLE: if (init_done_q) begin
          if (cmd_valid) begin
            cur_byte <= cmd_data;
            rs_q     <= 1'b0;
            sub      <= S_HI;
            state    <= SEND;
            if (is_slow_cmd(cmd_data)) begin
              row <= 2'd0;
              col <= 6'd0;
            end else if (cmd_data[7] && addr_hit) begin
              row <= hit_row;
              col <= hit_col;
            end
          end else if (ch_valid) begin
            pend_ch <= ch_data;
            sub     <= S_HI;
            if (col == COLS_L) begin
              cur_byte <= SET_DDRAM | {1'b0, row_base(next_row)};
              rs_q     <= 1'b0;
              row      <= next_row;
              col      <= 6'd0;
              state    <= ADDR;
            end else begin
              cur_byte <= ch_data;
              rs_q     <= 1'b1;
              col      <= col + 6'd1;
              state    <= SEND;
            end
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

  lcd_nibble_tx #(
    .SETUP_CYC (C_SETUP),
    .E_CYC     (C_EHIGH),
    .HOLD_CYC  (C_HOLD)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (tx_start),
    .nib    (tx_nib),
    .rs     (tx_rs_in),
    .done   (tx_done),
    .data   (tx_data),
    .rs_out (tx_rs),
    .e      (tx_e)
  );

  assign cmd_ready        = (state == IDLE) && init_done_q;
  assign ch_ready         = (state == IDLE) && init_done_q;
  assign init_done        = init_done_q;
  assign dataout          = tx_data;
  assign control[CTRL_E]  = tx_e;
  assign control[CTRL_RS] = tx_rs;
  assign control[CTRL_RW] = 1'b0;

endmodule

// File: tb/tb_lcd_nibble_ctrl.sv
// tb_lcd_nibble_ctrl: scoreboard bench for lcd_nibble_ctrl with scaled waits.
module tb_lcd_nibble_ctrl;

  localparam int CLK_HZ     = 50_000_000;
  localparam int COLS       = 16;
  localparam int ROWS       = 2;
  localparam int TIME_SCALE = 1000;
  localparam int PWR_CYC    = 750;   // 15 ms at 50 MHz / 1000
  localparam int E_CYC      = 12;    // 230 ns at 50 MHz, rounded up
  localparam int CLR_MIN    = 112;   // 1.64 ms / 1000 = 82 cycles plus two nibbles
  localparam int BYTE_MIN   = 33;    // two nibbles plus gap plus 40 us / 1000

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0, ch_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00, ch_data = 8'h00;
  logic       cmd_ready, ch_ready, init_done;
  logic [3:0] dataout;
  logic [2:0] control;

  int errors = 0;
  int checks = 0;

  typedef struct packed {logic single; logic rs; logic [7:0] val;} exp_t;
  exp_t exp_q[$];
  exp_t e_item;
  int   mdl_row = 0, mdl_col = 0;

  always #10 clk = ~clk;

  lcd_nibble_ctrl #(
    .CLK_HZ     (CLK_HZ),
    .COLS       (COLS),
    .ROWS       (ROWS),
    .TIME_SCALE (TIME_SCALE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .ch_ready  (ch_ready),
    .init_done (init_done),
    .dataout   (dataout),
    .control   (control)
  );

  function automatic int tb_row_base(input int r);
    case (r)
      0:       return 'h00;
      1:       return 'h40;
      2:       return 'h14;
      default: return 'h54;
    endcase
  endfunction

  task automatic push_exp(input logic single, input logic rs, input logic [7:0] val);
    exp_t x;
    x.single = single;
    x.rs     = rs;
    x.val    = val;
    exp_q.push_back(x);
  endtask

  task automatic push_init();
    push_exp(1'b1, 1'b0, 8'h03);
    push_exp(1'b1, 1'b0, 8'h03);
    push_exp(1'b1, 1'b0, 8'h03);
    push_exp(1'b1, 1'b0, 8'h02);
    push_exp(1'b0, 1'b0, 8'h28);
    push_exp(1'b0, 1'b0, 8'h06);
    push_exp(1'b0, 1'b0, 8'h0C);
    push_exp(1'b0, 1'b0, 8'h01);
    mdl_row = 0;
    mdl_col = 0;
  endtask

  task automatic expect_char(input logic [7:0] c);
    if (mdl_col == COLS) begin
      mdl_row = (mdl_row == ROWS - 1) ? 0 : mdl_row + 1;
      push_exp(1'b0, 1'b0, 8'(8'h80 | tb_row_base(mdl_row)));
      mdl_col = 0;
    end
    push_exp(1'b0, 1'b1, c);
    mdl_col++;
  endtask

  task automatic expect_cmd(input logic [7:0] c);
    push_exp(1'b0, 1'b0, c);
    if (c == 8'h01 || c == 8'h02 || c == 8'h03) begin
      mdl_row = 0;
      mdl_col = 0;
    end else if (c[7]) begin
      for (int r = ROWS - 1; r >= 0; r--) begin
        int b = tb_row_base(r);
        if (int'(c[6:0]) >= b && int'(c[6:0]) < b + COLS) begin
          mdl_row = r;
          mdl_col = int'(c[6:0]) - b;
        end
      end
    end
  endtask

  // Bus monitor: captures each E pulse, checks its shape and scores nibbles/bytes
  logic       prev_e = 1'b0, have_hi = 1'b0;
  logic [3:0] hi_nib, rise_data;
  logic       hi_rs, rise_rs;
  int         e_len = 0;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_e  = 1'b0;
      have_hi = 1'b0;
      e_len   = 0;
    end else begin
      if (control[2] === 1'b1) begin
        if (!prev_e) begin
          rise_data = dataout;
          rise_rs   = control[1];
          e_len     = 0;
        end
        e_len++;
      end else if (prev_e) begin
        checks++;
        if (e_len != E_CYC || dataout !== rise_data || control[1] !== rise_rs || control[0] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL e_pulse: width=%0d data %h->%h rs %b->%b rw=%b, required width=%0d with stable data/rs, rw=0",
                   e_len, rise_data, dataout, rise_rs, control[1], control[0], E_CYC);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_nibble: got rs=%b nib=%h, required no bus activity", rise_rs, rise_data);
        end else if (exp_q[0].single) begin
          e_item = exp_q.pop_front();
          checks++;
          if ({rise_rs, rise_data} !== {e_item.rs, e_item.val[3:0]}) begin
            errors++;
            $display("[TB] FAIL init_nibble: got rs=%b nib=%h, required rs=%b nib=%h",
                     rise_rs, rise_data, e_item.rs, e_item.val[3:0]);
          end
        end else if (!have_hi) begin
          have_hi = 1'b1;
          hi_nib  = rise_data;
          hi_rs   = rise_rs;
        end else begin
          have_hi = 1'b0;
          e_item  = exp_q.pop_front();
          checks++;
          if ({hi_rs, rise_rs, hi_nib, rise_data} !== {e_item.rs, e_item.rs, e_item.val}) begin
            errors++;
            $display("[TB] FAIL bus_byte: got rs=%b/%b byte=%h%h, required rs=%b byte=%h",
                     hi_rs, rise_rs, hi_nib, rise_data, e_item.rs, e_item.val);
          end
        end
      end
      prev_e = (control[2] === 1'b1);
    end
  end

  task automatic run_init(input string tag);
    int n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    while (control[2] !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (control[2] !== 1'b1 || n < PWR_CYC) begin
      errors++;
      $display("[TB] FAIL %s_first_e: E after %0d cycles, required >= %0d", tag, n, PWR_CYC);
    end
    checks++;
    if (dataout !== 4'h3 || control[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_first_nibble: got data=%h rs=%b, required data=3 rs=0", tag, dataout, control[1]);
    end
    n = 0;
    while (init_done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (init_done !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_init_done: init_done=%b cmd_ready=%b, required 1/1", tag, init_done, cmd_ready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_init_seq: %0d items left, required 0", tag, exp_q.size());
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    @(negedge clk);
    while (!(cmd_ready === 1'b1 && exp_q.size() == 0 && !have_hi) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: ready=%b pending=%0d, required ready=1 pending=0", tag, cmd_ready, exp_q.size());
    end
  endtask

  task automatic send_ch(input logic [7:0] c);
    int n = 0;
    expect_char(c);
    @(negedge clk);
    ch_data  = c;
    ch_valid = 1'b1;
    while (ch_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ch_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ch_accept: ch_ready=%b after %0d cycles, required 1", ch_ready, n);
    end
    @(posedge clk);
    #1 ch_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    int n = 0;
    expect_cmd(c);
    @(negedge clk);
    cmd_data  = c;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dataout !== 4'h0 || control !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_bus: data=%h control=%b, required 0/000", dataout, control);
    end
    checks++;
    if (cmd_ready !== 1'b0 || ch_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: cmd=%b ch=%b, required 0/0", cmd_ready, ch_ready);
    end
    checks++;
    if (init_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_init_done: got %b, required 0", init_done);
    end
    push_init();
    run_init("por");
  endtask

  task automatic test_char();
    int n = 0;
    send_ch(8'h41);
    checks++;
    if (ch_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ch_ready_drop: got %b, required 0", ch_ready);
    end
    while (ch_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ch_ready !== 1'b1 || n < BYTE_MIN) begin
      errors++;
      $display("[TB] FAIL char_busy: ready low %0d cycles, required >= %0d then high", n, BYTE_MIN);
    end
    wait_drain("char");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 32; i++) send_ch(8'($urandom_range(8'h20, 8'h7E)));
    wait_drain("wrap");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    cmd_data  = 8'h01;
    ch_data   = 8'h5A;
    cmd_valid = 1'b1;
    ch_valid  = 1'b1;
    expect_cmd(8'h01);
    expect_char(8'h5A);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    checks++;
    if (ch_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_ready_drop: got %b, required 0", ch_ready);
    end
    n = 0;
    while (ch_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ch_ready !== 1'b1 || n < CLR_MIN) begin
      errors++;
      $display("[TB] FAIL clear_wait: ready low %0d cycles, required >= %0d then high", n, CLR_MIN);
    end
    @(posedge clk);
    #1 ch_valid = 1'b0;
    wait_drain("b2b");
  endtask

  task automatic test_cmd_addr();
    send_cmd(8'hC5);
    send_cmd(8'h9F);
    send_cmd(8'h0C);
    for (int i = 0; i < 12; i++) send_ch(8'(8'h30 + i));
    wait_drain("cmd_addr");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    send_ch(8'h33);
    while (control[2] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (control[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_e_high: E=%b, required 1", control[2]);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (control !== 3'b000 || dataout !== 4'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_bus: control=%b data=%h, required 000/0", control, dataout);
    end
    checks++;
    if (init_done !== 1'b0 || ch_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_status: init_done=%b ch_ready=%b, required 0/0", init_done, ch_ready);
    end
    exp_q.delete();
    push_init();
    repeat (2) @(negedge clk);
    run_init("mid");
    send_ch(8'h21);
    wait_drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_char();
    test_wrap();
    test_back_to_back();
    test_cmd_addr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_ctrl.md
LCD_NIBBLE_CTRL -- requirements
Module: lcd_nibble_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter COLS, default 16, visible characters per row (legal 1..40).
REQ-003 SHALL have parameter ROWS, default 2, display rows (legal 1..4).
REQ-004 SHALL have parameter TIME_SCALE, default 1, divisor applied to every wait of 1 us or longer (simulation speed-up only).
REQ-005 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port cmd_valid, input, 1, raw instruction request.
REQ-008 SHALL have port cmd_data, input, 8, raw instruction byte (RS=0).
REQ-009 SHALL have port cmd_ready, output, 1, instruction accepted when cmd_valid&cmd_ready.
REQ-010 SHALL have port ch_valid, input, 1, character write request.
REQ-011 SHALL have port ch_data, input, 8, character code (RS=1).
REQ-012 SHALL have port ch_ready, output, 1, character accepted when ch_valid&ch_ready.
REQ-013 SHALL have port init_done, output, 1, high once power-on and config sequence completes.
REQ-014 SHALL have port dataout, output, 4, LCD D[7:4].
REQ-015 SHALL have port control, output, 3, {E, RS, RW}; RW always 0.

Function
REQ-016 Wait counts SHALL be ceil(t*CLK_HZ) cycles, floored at 1; waits >= 1 us divided by TIME_SCALE (floor 1); counter width via $clog2 of largest count.
REQ-017 Power-on: 15 ms idle; nibble 0x3, 4.1 ms; 0x3, 100 us; 0x3, 40 us; 0x2, 40 us.
REQ-018 Config, as full bytes: 0x28, 0x06, 0x0C, 0x01; then 1.64 ms; then init_done=1, cursor=(row 0,col 0).
REQ-019 Byte transfer: high nibble then low nibble, each: data/RS setup 40 ns, E high 230 ns (12 cycles at 50 MHz), E low hold 10 ns.
REQ-020 Byte transfer timing: 1 us gap between nibbles; 40 us after byte; 1.64 ms after instructions 0x01, 0x02, 0x03.
REQ-021 FSM states SHALL be PWR_WAIT, INIT_NIB, CFG, IDLE, ADDR, SEND, POST_WAIT; reset enters PWR_WAIT.
REQ-022 cmd_ready and ch_ready SHALL be high only in IDLE with init_done=1; acceptance latched same cycle, ready drops next cycle.
REQ-023 Simultaneous cmd_valid and ch_valid SHALL accept cmd only; ch held until a later IDLE.
REQ-024 Character write: if cursor col==COLS, first send Set-DDRAM 0x80|ROW_BASE[next row] (ADDR state), col=0; then send char, col+1.
REQ-025 Row wrap: next row of ROWS-1 SHALL be row 0; ROW_BASE = 0x00, 0x40, 0x14, 0x54.
REQ-026 cmd 0x01/0x02/0x03 SHALL reset cursor to (0,0); cmd with bit7 set SHALL set cursor if address matches a row base+col<COLS, else leave cursor unchanged.
REQ-027 All other cmd bytes SHALL pass through unchanged without cursor effect.
REQ-028 dataout SHALL change only while E low; E SHALL never be high during RS or data change.

Reset
REQ-029 rst_n low SHALL asynchronously force dataout=0, control=0, cmd_ready=0, ch_ready=0, init_done=0, cursor=(0,0), counters=0.
REQ-030 Reset mid-transfer SHALL abandon the byte; release restarts from PWR_WAIT with full 15 ms wait.

Structure
REQ-031 Package lcd_pkg SHALL hold control bit indices, command codes (CLEAR, HOME, FUNC_4B2L, ENTRY, DISP_ON), ROW_BASE table, timing constants in ns.
REQ-032 Sub-module lcd_nibble_tx SHALL perform one timed nibble (setup/E/hold) with start/done handshake; top FSM sequences it.

Verification
REQ-033 Reset release at CLK_HZ=50 MHz, TIME_SCALE=1 -> first E rise after >=750_000 cycles, dataout=0x3; init_done after nibbles 3,3,3,2 then bytes 28,06,0C,01.
REQ-034 TIME_SCALE=1000, send ch 0x41 after init_done -> RS=1, nibbles 0x4 then 0x1, E high 12 cycles each, ch_ready low until 40 us/1000 wait ends.
REQ-035 COLS=16, ROWS=2: 17 chars -> byte 0xC0 with RS=0 before char 17; 33 chars -> 0x80 before char 33.
REQ-036 cmd_valid and ch_valid same cycle -> cmd byte transferred first, char next; cmd 0x01 -> 1.64 ms/TIME_SCALE wait, next char lands at (0,0) with no address byte.
REQ-037 rst_n low during E high of a char -> control=0, dataout=0 immediately; after release init sequence repeats from start.
REQ-038 cmd 0xC5 with COLS=16 -> cursor (1,5); next char at col 5, address byte emitted after col 15 char wraps to 0x80.
